seven_seg_scan_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter that drives a time-multiplexed, active-low seven-segment display. It generalises the single-digit 0–9 demo counter with several additions:
- N digits and selectable count direction.
- Load, clear and enable controls, plus a wrap pulse.
- Its own count and scan prescalers derived from the clock frequency.
- Anti-ghost blanking between digits.

It sits between board-level `clk` and the display pins, and exposes the counter value for other logic.

---
 rtl/seven_seg_scan_counter.sv | 216 +++++++++++++++++++++
 tb/tb_seven_seg_scan_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_counter.sv
// Multi-digit BCD up/down counter driving a multiplexed active-low seven-segment display.
// Define SEVSEG_LZB_EN to blank leading zeros on every digit above digit 0.
module seven_seg_scan_counter #(
    parameter int                    NUM_DIGITS = 4,
    parameter int                    CLK_HZ     = 100_000_000,
    parameter int                    COUNT_HZ   = 3,
    parameter int                    SCAN_HZ    = 1000,
    parameter logic [NUM_DIGITS-1:0] DP_MASK    = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    wrap,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [0:6]              seg,
    output logic                    dp
);

    localparam int COUNT_DIV = CLK_HZ / COUNT_HZ;
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int CW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW        = $clog2(SCAN_DIV);
    localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int W         = 4 * NUM_DIGITS;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    logic [CW-1:0]   count_q;
    logic            tick;
    logic [W-1:0]    inc_val;
    logic [W-1:0]    dec_val;
    logic [W-1:0]    san_val;
    logic            carry;
    logic            borrow;
    logic [3:0]      digit;
    logic [3:0]      ld_digit;

    scan_state_t     state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [0:6]      seg_d;
    logic            dp_d;
    logic [3:0]      cur_digit;
    logic            cur_dp;
    logic            cur_blank;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic            zero_run;

    function automatic logic [0:6] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h01;
            4'd1:    decode = 7'h4F;
            4'd2:    decode = 7'h12;
            4'd3:    decode = 7'h06;
            4'd4:    decode = 7'h4C;
            4'd5:    decode = 7'h24;
            4'd6:    decode = 7'h20;
            4'd7:    decode = 7'h0F;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h04;
            default: decode = 7'h7F;
        endcase
    endfunction

    assign tick = en && (count_q == CW'(COUNT_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tick ? '0 : count_q + 1'b1;
        end
    end

    // Ripple carry/borrow through the digits; the final carry/borrow means all-9s/all-0s wrapped.
    always_comb begin
        inc_val  = '0;
        dec_val  = '0;
        san_val  = '0;
        carry    = 1'b1;
        borrow   = 1'b1;
        digit    = '0;
        ld_digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit    = value[4*k +: 4];
            ld_digit = load_val[4*k +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                inc_val[4*k +: 4] = digit;
            end
            if (borrow) begin
                if (digit == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end else begin
                    dec_val[4*k +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                dec_val[4*k +: 4] = digit;
            end
            san_val[4*k +: 4] = (ld_digit > 4'd9) ? 4'd0 : ld_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
            wrap  <= 1'b0;
        end else if (clear) begin
            value <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            value <= san_val;
            wrap  <= 1'b0;
        end else if (tick) begin
            value <= up ? inc_val : dec_val;
            wrap  <= up ? carry : borrow;
        end else begin
            wrap  <= 1'b0;
        end
    end

`ifdef SEVSEG_LZB_EN
    // A digit is blank when it and everything above it are zero; digit 0 always shows.
    always_comb begin
        blank_vec = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (value[4*k +: 4] == 4'd0);
            blank_vec[k] = zero_run;
        end
    end
`else
    always_comb begin
        blank_vec = '0;
        zero_run  = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BLANK;
            idx_q      <= '0;
            scan_cnt_q <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            scan_cnt_q <= scan_cnt_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
        end
    end

    // Display pins are registered from the next state so they change together with the FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        scan_cnt_d = scan_cnt_q;
        an_d       = '1;
        seg_d      = 7'h7F;
        dp_d       = 1'b1;
        cur_digit  = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        case (state_q)
            BLANK: begin
                state_d    = DRIVE;
                scan_cnt_d = '0;
            end
            DRIVE: begin
                if (scan_cnt_q == SW'(SCAN_DIV - 2)) begin
                    state_d    = BLANK;
                    scan_cnt_d = '0;
                    idx_d      = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
        if (state_d == DRIVE) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_d == IW'(k)) begin
                    an_d[k]   = 1'b0;
                    cur_digit = value[4*k +: 4];
                    cur_dp    = DP_MASK[k];
                    cur_blank = blank_vec[k];
                end
            end
            seg_d = cur_blank ? 7'h7F : decode(cur_digit);
            dp_d  = ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_counter.sv
// Scoreboard bench for seven_seg_scan_counter: stimulus queues expected outputs, a negedge monitor compares.
// Expected leading-zero behaviour follows SEVSEG_LZB_EN as seen by this compile.
module tb_seven_seg_scan_counter;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic        up       = 1'b1;
    logic        clear    = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic [15:0] value;
    logic        wrap;
    logic [3:0]  an;
    logic [0:6]  seg;
    logic        dp;

    int edges    = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef enum int {K_VALUE, K_WRAP, K_AN, K_SEG, K_DP} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    seven_seg_scan_counter #(
        .NUM_DIGITS(4),
        .CLK_HZ    (100),
        .COUNT_HZ  (10),
        .SCAN_HZ   (25),
        .DP_MASK   (4'b0100)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .up      (up),
        .clear   (clear),
        .load    (load),
        .load_val(load_val),
        .value   (value),
        .wrap    (wrap),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // Edges since reset release: edge n sits at scan position (n-1)%4, digit ((n-1)/4)%4.
    always @(posedge clk) edges <= rst_n ? edges + 1 : 0;

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_VALUE: act = value;
                K_WRAP:  act = {15'b0, wrap};
                K_AN:    act = {12'b0, an};
                K_SEG:   act = {9'b0, seg};
                default: act = {15'b0, dp};
            endcase
            n_checks++;
            if (act === e.exp) n_pass++;
            else $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic l, input logic [15:0] lv,
                                 input logic e, input logic u, input int ncyc);
        clear    = c;
        load     = l;
        load_val = lv;
        en       = e;
        up       = u;
        for (int i = 0; i < ncyc; i++) begin
            tick_clk();
            clear = 1'b0;
            load  = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input kind_e k, input logic [15:0] v);
        exp_t e;
        e.name = name;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // segs packs the expected pattern of digit d at bits [7*d +: 7].
    task automatic checkScan(input string tag, input logic [27:0] segs, input int ncyc);
        logic [3:0] an_tab [4];
        int p;
        int d;
        an_tab[0] = 4'hE;
        an_tab[1] = 4'hD;
        an_tab[2] = 4'hB;
        an_tab[3] = 4'h7;
        for (int i = 0; i < ncyc; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
            p = (edges - 1) % 4;
            d = ((edges - 1) / 4) % 4;
            if (p == 3) begin
                checkOutput($sformatf("%s_blank_an", tag), K_AN, 16'h000F);
                checkOutput($sformatf("%s_blank_seg", tag), K_SEG, 16'h007F);
                checkOutput($sformatf("%s_blank_dp", tag), K_DP, 16'h0001);
            end else begin
                checkOutput($sformatf("%s_an_d%0d", tag, d), K_AN, {12'b0, an_tab[d]});
                checkOutput($sformatf("%s_seg_d%0d", tag, d), K_SEG, {9'b0, segs[7*d +: 7]});
                checkOutput($sformatf("%s_dp_d%0d", tag, d), K_DP, (d == 2) ? 16'h0000 : 16'h0001);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held three cycles
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 3);
        checkOutput("rst_an", K_AN, 16'h000F);
        checkOutput("rst_seg", K_SEG, 16'h007F);
        checkOutput("rst_dp", K_DP, 16'h0001);
        checkOutput("rst_value", K_VALUE, 16'h0000);
        checkOutput("rst_wrap", K_WRAP, 16'h0000);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
        checkOutput("first_drive_an", K_AN, 16'h000E);
        checkOutput("first_drive_seg", K_SEG, 16'h0001);
        checkOutput("first_drive_dp", K_DP, 16'h0001);

        // Up count with carry into the tens digit
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 16'h0009, 1'b0, 1'b1, 1);
        checkOutput("load_0009", K_VALUE, 16'h0009);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 9);
        checkOutput("up_pre_tick", K_VALUE, 16'h0009);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1);
        checkOutput("up_carry", K_VALUE, 16'h0010);
        checkOutput("up_carry_wrap", K_WRAP, 16'h0000);

        // Up wrap from all nines
        applyStimulus(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1);
        checkOutput("load_9999", K_VALUE, 16'h9999);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 10);
        checkOutput("up_wrap_value", K_VALUE, 16'h0000);
        checkOutput("up_wrap_pulse", K_WRAP, 16'h0001);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
        checkOutput("up_wrap_single", K_WRAP, 16'h0000);
        checkOutput("up_wrap_hold", K_VALUE, 16'h0000);

        // Down count with borrow, then wrap from zero
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 10);
        checkOutput("down_borrow", K_VALUE, 16'h0099);
        checkOutput("down_borrow_wrap", K_WRAP, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 10);
        checkOutput("down_wrap_value", K_VALUE, 16'h9999);
        checkOutput("down_wrap_pulse", K_WRAP, 16'h0001);

        // Load sanitising of non-BCD nibbles
        applyStimulus(1'b0, 1'b1, 16'hA3F7, 1'b0, 1'b1, 1);
        checkOutput("load_sanitise", K_VALUE, 16'h0307);

        // Clear + load + tick in one cycle: clear wins, no wrap
        applyStimulus(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 9);
        checkOutput("pre_clear_value", K_VALUE, 16'h9999);
        applyStimulus(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1, 1);
        checkOutput("clear_wins_value", K_VALUE, 16'h0000);
        checkOutput("clear_wins_wrap", K_WRAP, 16'h0000);

        // Load coincident with a tick consumes the tick
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 9);
        checkOutput("pre_load_tick", K_VALUE, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0042, 1'b1, 1'b1, 1);
        checkOutput("load_on_tick", K_VALUE, 16'h0042);
        checkOutput("load_on_tick_wrap", K_WRAP, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 9);
        checkOutput("tick_consumed", K_VALUE, 16'h0042);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1);
        checkOutput("next_tick_counts", K_VALUE, 16'h0043);

        // Scan order, segment decode and decimal point on digit 2
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1);
        checkScan("scan1234", {7'h4F, 7'h12, 7'h06, 7'h4C}, 20);

        // Leading zeros
        applyStimulus(1'b0, 1'b1, 16'h0050, 1'b0, 1'b1, 1);
`ifdef SEVSEG_LZB_EN
        checkScan("lzb0050", {7'h7F, 7'h7F, 7'h24, 7'h01}, 16);
`else
        checkScan("nolzb0050", {7'h01, 7'h01, 7'h24, 7'h01}, 16);
`endif

        // Reset mid-scan returns to BLANK at digit 0
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
        checkOutput("midrst_an", K_AN, 16'h000F);
        checkOutput("midrst_seg", K_SEG, 16'h007F);
        checkOutput("midrst_value", K_VALUE, 16'h0000);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);
        checkOutput("midrst_drive_an", K_AN, 16'h000E);
        checkOutput("midrst_drive_seg", K_SEG, 16'h0001);

        for (int i = 0; i < 5 && sb.size() > 0; i++) tick_clk();
        if (sb.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
